// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer between the load/store path and Data_Mem. Stores are
//   queued in a circular FIFO and drained in order, one per cycle in which the
//   memory port is not needed by a load that misses the buffer. Loads always
//   get the port first.
//
//   Build option: SB_FWD_EN
//     defined   - a load that hits a queued store is forwarded from the
//                 youngest matching entry (no stall, no memory read).
//     undefined - a load that hits a queued store stalls until no entry
//                 matches; ld_data is 0 while stalled.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     st_valid/st_addr/st_data      store request
//     st_ready                      store accepted when st_valid && st_ready
//     ld_valid/ld_addr              load request (combinational service)
//     ld_data, ld_stall             load result / load must be held
//     flush_req, flush_done         drain request / one-cycle completion pulse
//     count                         occupied entries
//     mem_read/mem_write/mem_addr/mem_wdata/mem_rdata   Data_Mem port
module store_buffer #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  input  logic [AW-1:0]                st_addr,
  input  logic [DW-1:0]                st_data,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_addr,
  output logic [DW-1:0]                ld_data,
  output logic                         ld_stall,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic [DW-1:0]                mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   slot;
  logic            hit;
  logic [DW-1:0]   fwd_data;
  logic            miss_rd;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;

  // Search only occupied slots, oldest to youngest, so the last match
  // (the youngest store to that address) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (ld_valid && (CW'(k) < count) && (addr_q[slot] == ld_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[slot];
      end
    end
  end

  // rst_n gates the port so nothing reaches Data_Mem while reset is held.
  assign miss_rd    = rst_n && ld_valid && !hit;
  assign pop        = rst_n && !miss_rd && (count != '0);
  assign st_ready   = (state == RUN) && (count < CW'(DEPTH));
  assign push       = st_valid && st_ready;
  assign count_next = count + CW'(push) - CW'(pop);

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_data   = '0;
    ld_stall  = 1'b0;
    if (miss_rd) begin
      mem_read = 1'b1;
      mem_addr = ld_addr;
      ld_data  = mem_rdata;
    end else if (pop) begin
      mem_write = 1'b1;
      mem_addr  = addr_q[head];
      mem_wdata = data_q[head];
    end
`ifdef SB_FWD_EN
    if (rst_n && hit) ld_data = fwd_data;
`else
    if (rst_n && hit) ld_stall = 1'b1;
`endif
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count      <= count_next;
      flush_done <= 1'b0;
      case (state)
        RUN:     if (flush_req) state <= FLUSH;
        FLUSH:   if (count_next == '0) begin
                   state      <= DONE;
                   flush_done <= 1'b1;
                 end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed bench for store_buffer (AW=8, DW=8, DEPTH=4). Accepted stores are
//   pushed into an expected-write queue; a monitor pops it on every mem_write
//   and compares address/data. Directed checks cover stalls, loads, flush and
//   reset. A small Data_Mem model answers mem_read.
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       st_valid = 1'b0;
  logic [7:0] st_addr = '0;
  logic [7:0] st_data = '0;
  logic       st_ready;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data;
  logic       ld_stall;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic [2:0] count;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0]  dmem [256];
  logic [15:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .flush_req(flush_req), .flush_done(flush_done), .count(count),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard producer: record each accepted store in issue order.
  always @(negedge clk) begin
    if (rst_n && st_valid && st_ready) exp_q.push_back({st_addr, st_data});
  end

  // Scoreboard consumer: every memory write must be the oldest outstanding store.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          check("write_order", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
        end
        check("rd_wr_exclusive", {31'h0, mem_read}, 32'h0);
      end
      if (count > 3'd4) check("count_bound", {29'h0, count}, 32'd4);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one store until accepted. If the buffer stays full, drop the load
  // so the drain can make progress.
  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (st_ready) ok = 1'b1;
      cyc();
      if (!ok) ld_valid = 1'b0;
    end
    if (!ok) check("store_accept_timeout", 32'h0, 32'h1);
    st_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    dmem[8'h80] = 8'h5A;

    // Reset state, with a load presented to prove the port stays quiet.
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    #1 rst_n = 1'b0;
    #2;
    check("rst_count",      {29'h0, count},      32'h0);
    check("rst_mem_read",   {31'h0, mem_read},   32'h0);
    check("rst_mem_write",  {31'h0, mem_write},  32'h0);
    check("rst_mem_addr",   {24'h0, mem_addr},   32'h0);
    check("rst_ld_data",    {24'h0, ld_data},    32'h0);
    check("rst_ld_stall",   {31'h0, ld_stall},   32'h0);
    check("rst_flush_done", {31'h0, flush_done}, 32'h0);
    ld_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // T1: three stores, each drained the cycle after acceptance.
    do_store(8'h10, 8'h11);
    @(negedge clk);
    check("t1_wr0", {23'h0, mem_write, mem_addr}, {23'h0, 1'b1, 8'h10});
    cyc();
    do_store(8'h20, 8'h22);
    @(negedge clk);
    check("t1_wr1", {23'h0, mem_write, mem_addr}, {23'h0, 1'b1, 8'h20});
    cyc();
    do_store(8'hFF, 8'h9C);
    @(negedge clk);
    check("t1_wr2", {15'h0, mem_write, mem_addr, mem_wdata}, {15'h0, 1'b1, 8'hFF, 8'h9C});
    cyc();
    @(negedge clk);
    check("t1_count_zero", {29'h0, count}, 32'h0);
    cyc();

    // T2: held load miss starves the drain; buffer fills at 4.
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    do_store(8'h01, 8'hA1);
    do_store(8'h02, 8'hA2);
    do_store(8'h03, 8'hA3);
    do_store(8'h04, 8'hA4);
    st_valid = 1'b1;
    st_addr  = 8'h05;
    st_data  = 8'hA5;
    @(negedge clk);
    check("t2_count_full", {29'h0, count},    32'd4);
    check("t2_not_ready",  {31'h0, st_ready}, 32'h0);
    check("t2_load_miss",  {15'h0, mem_read, mem_addr, ld_data}, {15'h0, 1'b1, 8'h80, 8'h5A});
    check("t2_no_write",   {31'h0, mem_write}, 32'h0);
    cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t2_full_draining_not_ready", {30'h0, st_ready, mem_write}, {30'h0, 1'b0, 1'b1});
    cyc();
    @(negedge clk);
    check("t2_ready_after_drain", {31'h0, st_ready}, 32'h1);
    cyc();
    st_valid = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    check("t2_count_zero", {29'h0, count}, 32'h0);
    cyc();

    // T3: two stores to 30 queued behind a blocking miss, then load 30.
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    do_store(8'h30, 8'h01);
    do_store(8'h30, 8'h02);
    ld_addr = 8'h30;
    @(negedge clk);
`ifdef SB_FWD_EN
    check("t3_p0_load", {23'h0, ld_stall, ld_data}, {23'h0, 1'b0, 8'h02});
`else
    check("t3_p0_load", {23'h0, ld_stall, ld_data}, {23'h0, 1'b1, 8'h00});
`endif
    check("t3_p0_write", {14'h0, mem_read, mem_write, mem_addr, mem_wdata}, {14'h0, 1'b0, 1'b1, 8'h30, 8'h01});
    check("t3_p0_count", {29'h0, count}, 32'd2);
    cyc();
    @(negedge clk);
`ifdef SB_FWD_EN
    check("t3_p1_load", {23'h0, ld_stall, ld_data}, {23'h0, 1'b0, 8'h02});
`else
    check("t3_p1_load", {23'h0, ld_stall, ld_data}, {23'h0, 1'b1, 8'h00});
`endif
    check("t3_p1_write", {15'h0, mem_write, mem_addr, mem_wdata}, {15'h0, 1'b1, 8'h30, 8'h02});
    cyc();
    @(negedge clk);
    check("t3_p2_read", {14'h0, ld_stall, mem_read, mem_addr, ld_data}, {14'h0, 1'b0, 1'b1, 8'h30, 8'h02});
    check("t3_p2_count", {29'h0, count}, 32'h0);
    cyc();
    ld_valid = 1'b0;

    // T4: flush with three queued entries.
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    do_store(8'h60, 8'hB0);
    do_store(8'h61, 8'hB1);
    do_store(8'h62, 8'hB2);
    ld_valid  = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    check("t4_a_count", {29'h0, count}, 32'd3);
    cyc();
    flush_req = 1'b0;
    @(negedge clk);
    check("t4_b", {27'h0, st_ready, flush_done, count}, {27'h0, 1'b0, 1'b0, 3'd2});
    cyc();
    @(negedge clk);
    check("t4_c", {27'h0, st_ready, flush_done, count}, {27'h0, 1'b0, 1'b0, 3'd1});
    cyc();
    @(negedge clk);
    check("t4_d_done", {27'h0, st_ready, flush_done, count}, {27'h0, 1'b0, 1'b1, 3'd0});
    cyc();
    @(negedge clk);
    check("t4_e_run", {30'h0, st_ready, flush_done}, {30'h0, 1'b1, 1'b0});
    cyc();

    // T4b: flush of an empty buffer pulses two cycles after the request.
    flush_req = 1'b1;
    @(negedge clk);
    check("t4b_a", {31'h0, flush_done}, 32'h0);
    cyc();
    flush_req = 1'b0;
    @(negedge clk);
    check("t4b_b", {30'h0, st_ready, flush_done}, {30'h0, 1'b0, 1'b0});
    cyc();
    @(negedge clk);
    check("t4b_c_done", {31'h0, flush_done}, 32'h1);
    cyc();
    @(negedge clk);
    check("t4b_d", {30'h0, st_ready, flush_done}, {30'h0, 1'b1, 1'b0});
    cyc();

    // T5: reset mid-drain discards the queue.
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    do_store(8'h70, 8'hC0);
    do_store(8'h71, 8'hC1);
    ld_valid = 1'b0;
    #1;
    check("t5_pre_write", {28'h0, mem_write, count}, {28'h0, 1'b1, 3'd2});
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_now", {28'h0, mem_write, count}, {28'h0, 1'b0, 3'd0});
    exp_q.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    check("t5_after_release", {27'h0, st_ready, mem_write, count}, {27'h0, 1'b1, 1'b0, 3'd0});
    cyc();

    // T6: twelve stores with interleaved misses; pointers wrap three times.
    for (int i = 0; i < 12; i++) begin
      ld_addr  = 8'hC0;
      ld_valid = (i % 3) != 2;
      do_store(8'(8'h40 + i), 8'(3 + i * 7));
    end
    ld_valid = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    check("t6_count_zero", {29'h0, count}, 32'h0);
    check("t6_queue_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
